// File: rtl/dnn_pkg.sv
// Shared definitions for the DNN hidden-layer aggregator: default widths,
// lane count, aggregation FSM states and the partial-vector type.
package dnn_pkg;

    localparam int DEF_IN_W  = 15;
    localparam int DEF_OUT_W = 17;
    localparam int NUM_LANES = 4;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } aggr_state_t;

    typedef logic [NUM_LANES-1:0][DEF_IN_W-1:0] relu_vec_t;

endpackage

// File: rtl/aggr_lane.sv
// One aggregation lane: clamps a signed ReLU value to non-negative, adds it
// into a saturating accumulator and reports per-beat clamp/saturation events.
module aggr_lane
    import dnn_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             add_i,
    input  logic [IN_W-1:0]  din_i,
    output logic [OUT_W-1:0] acc_o,
    output logic             neg_o,
    output logic             sat_o
);

    localparam logic [OUT_W:0] MAX_POS = {2'b00, {(OUT_W-1){1'b1}}};

    logic [OUT_W-1:0] acc_q;
    logic [OUT_W-1:0] acc_d;
    logic [OUT_W-1:0] addend;
    logic [OUT_W:0]   sum;
    logic             is_neg;
    logic             over;

    // Accumulator is always non-negative, so one extra bit catches overflow
    always_comb begin
        is_neg = din_i[IN_W-1];
        addend = is_neg ? '0 : OUT_W'(din_i);
        sum    = {1'b0, acc_q} + {1'b0, addend};
        over   = (sum > MAX_POS);
        acc_d  = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (add_i) begin
            acc_d = over ? MAX_POS[OUT_W-1:0] : sum[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;
    assign neg_o = add_i && is_neg;
    assign sat_o = add_i && over;

endmodule

// File: rtl/dnn_aggr.sv
// Collects NUM_SLICES partial ReLU vectors and hands their element-wise sum
// to the slices over a valid/ready channel, with sticky clamp/saturate flags.
module dnn_aggr
    import dnn_pkg::*;
#(
    parameter int NUM_SLICES = 4,
    parameter int IN_W       = DEF_IN_W,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int CNT_W      = $clog2(NUM_SLICES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             relu_valid,
    output logic             relu_ready,
    input  logic [IN_W-1:0]  y4_relu,
    input  logic [IN_W-1:0]  y5_relu,
    input  logic [IN_W-1:0]  y6_relu,
    input  logic [IN_W-1:0]  y7_relu,
    output logic             aggr_valid,
    input  logic             aggr_ready,
    output logic [OUT_W-1:0] y4_aggr,
    output logic [OUT_W-1:0] y5_aggr,
    output logic [OUT_W-1:0] y6_aggr,
    output logic [OUT_W-1:0] y7_aggr,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             neg_err,
    output logic             sat_err
);

    aggr_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_err_q, neg_err_d;
    logic             sat_err_q, sat_err_d;
    logic             beat;
    logic             lane_clear;

    logic [IN_W-1:0]  relu [NUM_LANES];
    logic [OUT_W-1:0] aggr [NUM_LANES];
    logic [NUM_LANES-1:0] lane_neg;
    logic [NUM_LANES-1:0] lane_sat;

    assign relu[0] = y4_relu;
    assign relu[1] = y5_relu;
    assign relu[2] = y6_relu;
    assign relu[3] = y7_relu;

    // A beat coinciding with flush is dropped; the handshake in DONE clears sums
    assign beat       = relu_valid && (state_q == ACCUM) && !flush;
    assign lane_clear = flush || ((state_q == DONE) && aggr_ready);

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        aggr_lane #(
            .IN_W (IN_W),
            .OUT_W(OUT_W)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .clear_i(lane_clear),
            .add_i  (beat),
            .din_i  (relu[k]),
            .acc_o  (aggr[k]),
            .neg_o  (lane_neg[k]),
            .sat_o  (lane_sat[k])
        );
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        neg_err_d = neg_err_q | (|lane_neg);
        sat_err_d = sat_err_q | (|lane_sat);
        if (flush) begin
            state_d   = ACCUM;
            cnt_d     = '0;
            neg_err_d = 1'b0;
            sat_err_d = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (beat) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(NUM_SLICES - 1)) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (aggr_ready) begin
                        state_d = ACCUM;
                        cnt_d   = '0;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ACCUM;
            cnt_q     <= '0;
            neg_err_q <= 1'b0;
            sat_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            neg_err_q <= neg_err_d;
            sat_err_q <= sat_err_d;
        end
    end

    assign relu_ready = (state_q == ACCUM);
    assign aggr_valid = (state_q == DONE);
    assign beat_cnt   = cnt_q;
    assign neg_err    = neg_err_q;
    assign sat_err    = sat_err_q;
    assign y4_aggr    = aggr[0];
    assign y5_aggr    = aggr[1];
    assign y6_aggr    = aggr[2];
    assign y7_aggr    = aggr[3];

endmodule

// File: tb/tb_dnn_aggr.sv
// Randomized self-checking bench for dnn_aggr: two instances (OUT_W 17 and 16)
// share stimulus and are compared every cycle against a behavioural model.
module tb_dnn_aggr;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        relu_valid = 1'b0;
    logic        aggr_ready = 1'b0;
    logic [14:0] y4 = '0, y5 = '0, y6 = '0, y7 = '0;

    logic        rdyA, avA, negA, satA;
    logic [2:0]  cntA;
    logic [16:0] a4A, a5A, a6A, a7A;
    logic        rdyB, avB, negB, satB;
    logic [2:0]  cntB;
    logic [15:0] a4B, a5B, a6B, a7B;

    int checks = 0;
    int errors = 0;

    int mAcc [2][4];
    int mCnt [2];
    bit mDone [2];
    bit mNeg [2];
    bit mSat [2];
    int mMax [2] = '{65535, 32767};

    always #5 clk = ~clk;

    dnn_aggr #(.NUM_SLICES(4), .IN_W(15), .OUT_W(17)) dutA (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .relu_valid(relu_valid), .relu_ready(rdyA),
        .y4_relu(y4), .y5_relu(y5), .y6_relu(y6), .y7_relu(y7),
        .aggr_valid(avA), .aggr_ready(aggr_ready),
        .y4_aggr(a4A), .y5_aggr(a5A), .y6_aggr(a6A), .y7_aggr(a7A),
        .beat_cnt(cntA), .neg_err(negA), .sat_err(satA)
    );

    dnn_aggr #(.NUM_SLICES(4), .IN_W(15), .OUT_W(16)) dutB (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .relu_valid(relu_valid), .relu_ready(rdyB),
        .y4_relu(y4), .y5_relu(y5), .y6_relu(y6), .y7_relu(y7),
        .aggr_valid(avB), .aggr_ready(aggr_ready),
        .y4_aggr(a4B), .y5_aggr(a5B), .y6_aggr(a6B), .y7_aggr(a7B),
        .beat_cnt(cntB), .neg_err(negB), .sat_err(satB)
    );

    // Reference model: a vector of running sums plus a "sum complete" flag
    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n || flush) begin
                for (int k = 0; k < 4; k++) mAcc[d][k] = 0;
                mCnt[d] = 0; mDone[d] = 0; mNeg[d] = 0; mSat[d] = 0;
            end else if (mDone[d]) begin
                if (aggr_ready) begin
                    for (int k = 0; k < 4; k++) mAcc[d][k] = 0;
                    mCnt[d] = 0; mDone[d] = 0;
                end
            end else if (relu_valid) begin
                int inVal [4];
                inVal = '{int'(y4), int'(y5), int'(y6), int'(y7)};
                for (int k = 0; k < 4; k++) begin
                    int v;
                    int s;
                    v = (inVal[k] >= 16384) ? 0 : inVal[k];
                    if (inVal[k] >= 16384) mNeg[d] = 1;
                    s = mAcc[d][k] + v;
                    if (s > mMax[d]) begin
                        s = mMax[d];
                        mSat[d] = 1;
                    end
                    mAcc[d][k] = s;
                end
                mCnt[d] = mCnt[d] + 1;
                if (mCnt[d] == 4) mDone[d] = 1;
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic compareDut(input int d, input logic rdy, input logic av, input logic [2:0] cnt,
                              input logic ne, input logic se, input logic [16:0] a4,
                              input logic [16:0] a5, input logic [16:0] a6, input logic [16:0] a7);
        string p;
        p = (d == 0) ? "w17" : "w16";
        checkOutput({p, ".relu_ready"}, int'(rdy), int'(!mDone[d]));
        checkOutput({p, ".aggr_valid"}, int'(av), int'(mDone[d]));
        checkOutput({p, ".beat_cnt"}, int'(cnt), mCnt[d]);
        checkOutput({p, ".neg_err"}, int'(ne), int'(mNeg[d]));
        checkOutput({p, ".sat_err"}, int'(se), int'(mSat[d]));
        if (mDone[d]) begin
            checkOutput({p, ".y4_aggr"}, int'(a4), mAcc[d][0]);
            checkOutput({p, ".y5_aggr"}, int'(a5), mAcc[d][1]);
            checkOutput({p, ".y6_aggr"}, int'(a6), mAcc[d][2]);
            checkOutput({p, ".y7_aggr"}, int'(a7), mAcc[d][3]);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            compareDut(0, rdyA, avA, cntA, negA, satA, a4A, a5A, a6A, a7A);
            compareDut(1, rdyB, avB, cntB, negB, satB, {1'b0, a4B}, {1'b0, a5B},
                       {1'b0, a6B}, {1'b0, a7B});
        end
    end

    task automatic applyStimulus(input logic v, input logic r, input logic f,
                                 input int d4, input int d5, input int d6, input int d7);
        @(posedge clk);
        #1;
        relu_valid = v; aggr_ready = r; flush = f;
        y4 = 15'(d4); y5 = 15'(d5); y6 = 15'(d6); y7 = 15'(d7);
    endtask

    function automatic int randRelu();
        if ($urandom_range(0, 7) == 0) return 16384 + int'($urandom_range(0, 16383));
        return int'($urandom_range(0, 16383));
    endfunction

    initial begin
        #12;
        checkOutput("reset.relu_ready", int'(rdyA), 1);
        checkOutput("reset.aggr_valid", int'(avA), 0);
        checkOutput("reset.y4_aggr", int'(a4A), 0);
        checkOutput("reset.beat_cnt", int'(cntA), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic sum
        applyStimulus(1, 0, 0, 10, 20, 30, 40);
        applyStimulus(1, 0, 0, 1, 2, 3, 4);
        applyStimulus(1, 0, 0, 100, 0, 0, 0);
        applyStimulus(1, 0, 0, 5, 5, 5, 5);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("basic.aggr_valid", int'(avA), 1);
        checkOutput("basic.relu_ready", int'(rdyA), 0);
        checkOutput("basic.y4", int'(a4A), 116);
        checkOutput("basic.y5", int'(a5A), 27);
        checkOutput("basic.y6", int'(a6A), 38);
        checkOutput("basic.y7", int'(a7A), 49);

        // Backpressure: valid held in DONE must not be taken
        repeat (5) applyStimulus(1, 0, 0, 9, 9, 9, 9);
        applyStimulus(1, 1, 0, 9, 9, 9, 9);
        checkOutput("bp.beat_cnt", int'(cntA), 4);
        checkOutput("bp.y4_held", int'(a4A), 116);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("bp.y4_cleared", int'(a4A), 0);
        checkOutput("bp.relu_ready", int'(rdyA), 1);

        // Negative clamp, flag persists across a handshake
        applyStimulus(1, 0, 0, 7, 'h7FFD, 7, 7);
        repeat (3) applyStimulus(1, 0, 0, 1, 1, 1, 1);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("neg.y4", int'(a4A), 10);
        checkOutput("neg.y5", int'(a5A), 3);
        checkOutput("neg.neg_err", int'(negA), 1);
        repeat (4) applyStimulus(1, 0, 0, 2, 2, 2, 2);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("neg.sticky", int'(negA), 1);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("neg.flushed", int'(negA), 0);

        // Max values: no saturation at 17 bits, saturation at 16 bits
        repeat (4) applyStimulus(1, 0, 0, 16383, 16383, 16383, 16383);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("max.w17.y6", int'(a6A), 65532);
        checkOutput("max.w17.sat", int'(satA), 0);
        checkOutput("max.w16.y6", int'(a6B), 32767);
        checkOutput("max.w16.sat", int'(satB), 1);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);

        // Flush with a coincident beat drops that beat
        applyStimulus(1, 0, 0, 1, 1, 1, 1);
        applyStimulus(1, 0, 0, 1, 1, 1, 1);
        applyStimulus(1, 0, 1, 50, 50, 50, 50);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("flush.beat_cnt", int'(cntA), 0);
        repeat (4) applyStimulus(1, 0, 0, 2, 2, 2, 2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("flush.y7", int'(a7A), 8);

        // Asynchronous reset while in DONE
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("areset.aggr_valid", int'(avA), 0);
        checkOutput("areset.relu_ready", int'(rdyA), 1);
        checkOutput("areset.y7", int'(a7A), 0);
        checkOutput("areset.beat_cnt", int'(cntA), 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                          $urandom_range(0, 40) == 0,
                          randRelu(), randRelu(), randRelu(), randRelu());
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
